// File: rtl/lc3b_types.sv
// Shared LC-3b types: register index, opcodes and the hazard shadow-pipe entry.
package lc3b_types;

  localparam int unsigned REG_W = 3;
  localparam int unsigned OPC_W = 4;

  typedef logic [REG_W-1:0] lc3b_reg;

  typedef enum logic [OPC_W-1:0] {
    OP_BR   = 4'b0000,
    OP_ADD  = 4'b0001,
    OP_LDB  = 4'b0010,
    OP_STB  = 4'b0011,
    OP_JSR  = 4'b0100,
    OP_AND  = 4'b0101,
    OP_LDR  = 4'b0110,
    OP_STR  = 4'b0111,
    OP_RTI  = 4'b1000,
    OP_NOT  = 4'b1001,
    OP_LDI  = 4'b1010,
    OP_STI  = 4'b1011,
    OP_JMP  = 4'b1100,
    OP_SHF  = 4'b1101,
    OP_LEA  = 4'b1110,
    OP_TRAP = 4'b1111
  } lc3b_opcode;

  // Destination-side summary of one in-flight instruction.
  typedef struct packed {
    logic    valid;
    lc3b_reg dest;
    logic    reg_write;
    logic    is_load;
    logic    mem_access;
  } hazard_entry_t;

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at its maximum value instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] MAX_COUNT = '1;

  // Increment on each event until saturated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != MAX_COUNT)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/hazard_control_unit.sv
// Stall/squash controller: load-use bubbles, data-memory wait stalls and
// taken-branch flushes, driven from a private shadow of EX/MEM/WB.
module hazard_control_unit
  import lc3b_types::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  lc3b_reg          id_sr1,
  input  lc3b_reg          id_sr2,
  input  logic             id_uses_sr1,
  input  logic             id_uses_sr2,
  input  lc3b_reg          id_dest,
  input  logic             id_reg_write,
  input  logic             id_is_load,
  input  logic             id_mem_access,
  input  logic             dmem_resp,
  input  logic             br_taken,
  output logic             stall_front,
  output logic             stall_back,
  output logic             bubble_ex,
  output logic             flush,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] bubble_count,
  output logic [CNT_W-1:0] flush_count
);

  hazard_entry_t ex_q, mem_q, wb_q;
  hazard_entry_t ex_d, mem_d, wb_d;
  hazard_entry_t id_entry;
  logic          mem_wait;
  logic          load_use;
  logic          unused_shadow;

  // WB copy is tracked for completeness; only EX/MEM fields steer control.
  assign unused_shadow = ^{ex_q, mem_q, wb_q};

  // Pack the ID-stage fields the shadow needs.
  always_comb begin
    id_entry            = '0;
    id_entry.valid      = id_valid;
    id_entry.dest       = id_dest;
    id_entry.reg_write  = id_reg_write;
    id_entry.is_load    = id_is_load;
    id_entry.mem_access = id_mem_access;
  end

  // Raw hazard terms.
  assign mem_wait = mem_q.valid & mem_q.mem_access & ~dmem_resp;
  assign load_use = id_valid & ex_q.valid & ex_q.is_load & ex_q.reg_write &
                    ((id_uses_sr1 & (id_sr1 == ex_q.dest)) |
                     (id_uses_sr2 & (id_sr2 == ex_q.dest)));

  // Prioritised controls (mem_wait > br_taken > load_use) and shadow advance.
  always_comb begin
    stall_front = 1'b0;
    stall_back  = 1'b0;
    bubble_ex   = 1'b0;
    flush       = 1'b0;
    ex_d        = id_entry;
    mem_d       = ex_q;
    wb_d        = mem_q;
    if (mem_wait) begin
      stall_front = 1'b1;
      stall_back  = 1'b1;
      ex_d        = ex_q;
      mem_d       = mem_q;
      wb_d        = wb_q;
    end else if (br_taken) begin
      flush = 1'b1;
      ex_d  = '0;
      mem_d = '0;
    end else if (load_use) begin
      stall_front = 1'b1;
      bubble_ex   = 1'b1;
      ex_d        = '0;
    end
  end

  // Shadow pipe registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (mem_wait),
    .count (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (bubble_ex),
    .count (bubble_count)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush),
    .count (flush_count)
  );

endmodule
